// File: rtl/alarm_controller.sv
// Control FSM of the alarm clock: sequences keypad entry into the key buffer and
// strobes alarm/time loads, aborting entry after TIMEOUT_SEC seconds of inactivity.
module alarm_controller #(
  parameter logic [3:0]  NOKEY       = 4'd10,
  parameter int unsigned TIMEOUT_SEC = 10
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       one_second,
  input  logic [3:0] key,
  input  logic       alarm_button,
  input  logic       time_button,
  output logic       show_alarm,
  output logic       show_new_time,
  output logic       shift,
  output logic       load_new_a,
  output logic       load_new_c
);

  localparam int unsigned TW = (TIMEOUT_SEC > 1) ? $clog2(TIMEOUT_SEC) : 1;

  typedef enum logic [2:0] {
    SHOW_TIME  = 3'd0,
    KEY_STORED = 3'd1,
    KEY_WAITED = 3'd2,
    KEY_ENTRY  = 3'd3,
    SHOW_ALARM = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          time_out;
  logic          key_pressed;

  assign key_pressed = (key != NOKEY);
  assign time_out    = one_second && (tcnt_q == TW'(TIMEOUT_SEC - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= SHOW_TIME;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
    end
  end

  // Buttons beat keys, keys beat the timeout.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      SHOW_TIME: begin
        if (alarm_button)     state_d = SHOW_ALARM;
        else if (key_pressed) state_d = KEY_STORED;
      end
      KEY_STORED: state_d = KEY_WAITED;
      KEY_WAITED: begin
        if (!key_pressed)  state_d = KEY_ENTRY;
        else if (time_out) state_d = SHOW_TIME;
      end
      KEY_ENTRY: begin
        if (alarm_button || time_button) state_d = SHOW_TIME;
        else if (key_pressed)            state_d = KEY_STORED;
        else if (time_out)               state_d = SHOW_TIME;
      end
      SHOW_ALARM: begin
        if (!alarm_button) state_d = SHOW_TIME;
      end
      default: state_d = SHOW_TIME;
    endcase
  end

  always_comb begin
    tcnt_d = '0;
    if ((state_d == state_q) &&
        ((state_q == KEY_WAITED) || (state_q == KEY_ENTRY))) begin
      tcnt_d = one_second ? tcnt_q + 1'b1 : tcnt_q;
    end
  end

  // Outputs are forced low while reset is asserted, even before the state clears.
  always_comb begin
    show_alarm    = 1'b0;
    show_new_time = 1'b0;
    shift         = 1'b0;
    load_new_a    = 1'b0;
    load_new_c    = 1'b0;
    if (!reset) begin
      show_alarm    = (state_q == SHOW_ALARM);
      show_new_time = (state_q == KEY_STORED) || (state_q == KEY_WAITED) ||
                      (state_q == KEY_ENTRY);
      shift         = (state_q == KEY_STORED);
      load_new_a    = (state_q == KEY_ENTRY) && alarm_button;
      load_new_c    = (state_q == KEY_ENTRY) && !alarm_button && time_button;
    end
  end

endmodule

// File: tb/tb_alarm_controller.sv
// Directed bench for alarm_controller; outputs are checked as the packed vector
// {show_alarm, show_new_time, shift, load_new_a, load_new_c}.
module tb_alarm_controller;

  localparam logic [3:0] NK = 4'd10;

  localparam logic [4:0] O_IDLE  = 5'b00000;
  localparam logic [4:0] O_ALARM = 5'b10000;
  localparam logic [4:0] O_ENTRY = 5'b01000;
  localparam logic [4:0] O_SHIFT = 5'b01100;
  localparam logic [4:0] O_LDA   = 5'b01010;
  localparam logic [4:0] O_LDC   = 5'b01001;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       one_second = 1'b0;
  logic [3:0] key = NK;
  logic       alarm_button = 1'b0;
  logic       time_button = 1'b0;
  logic       show_alarm, show_new_time, shift, load_new_a, load_new_c;
  logic [4:0] outs;

  int unsigned errors = 0;
  int unsigned checks = 0;

  alarm_controller #(.NOKEY(4'd10), .TIMEOUT_SEC(10)) dut (
    .clock        (clock),
    .reset        (reset),
    .one_second   (one_second),
    .key          (key),
    .alarm_button (alarm_button),
    .time_button  (time_button),
    .show_alarm   (show_alarm),
    .show_new_time(show_new_time),
    .shift        (shift),
    .load_new_a   (load_new_a),
    .load_new_c   (load_new_c)
  );

  always #5 clock = ~clock;

  assign outs = {show_alarm, show_new_time, shift, load_new_a, load_new_c};

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_sec();
    one_second = 1'b1;
    tick();
    one_second = 1'b0;
    #1;
  endtask

  // From SHOW_TIME: press key d for one cycle, release, land in KEY_ENTRY.
  task automatic enter_digit(input logic [3:0] d);
    key = d;
    tick();
    key = NK;
    tick();
    tick();
  endtask

  int unsigned nshift;

  initial begin
    // Reset state
    tick(); tick();
    #1 check("reset_outs", {3'b0, outs}, {3'b0, O_IDLE});
    check("reset_tcnt", {4'b0, dut.tcnt_q}, 8'd0);
    reset = 1'b0;
    #1;

    // Test 2: key held 4 cycles yields a single shift
    nshift = 0;
    key = 4'd3;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (shift) nshift++;
      if (i == 0) check("t2_stored", {3'b0, outs}, {3'b0, O_SHIFT});
    end
    check("t2_held_waited", {3'b0, outs}, {3'b0, O_ENTRY});
    key = NK;
    tick();
    if (shift) nshift++;
    check("t2_entry", {3'b0, outs}, {3'b0, O_ENTRY});
    check("t2_shift_count", nshift[7:0], 8'd1);
    key = 4'd7;
    tick();
    check("t2_second_shift", {3'b0, outs}, {3'b0, O_SHIFT});
    key = NK;
    tick();
    check("t2_second_waited", {3'b0, outs}, {3'b0, O_ENTRY});
    tick();

    // Test 3: both buttons in KEY_ENTRY -> alarm load wins
    alarm_button = 1'b1;
    time_button  = 1'b1;
    #1 check("t3_load_a", {3'b0, outs}, {3'b0, O_LDA});
    tick();
    check("t3_show_time", {3'b0, outs}, {3'b0, O_IDLE});
    time_button = 1'b0;
    tick();
    check("t3_show_alarm", {3'b0, outs}, {3'b0, O_ALARM});
    tick();
    check("t3_alarm_held", {3'b0, outs}, {3'b0, O_ALARM});
    alarm_button = 1'b0;
    tick();
    check("t3_release", {3'b0, outs}, {3'b0, O_IDLE});

    // time_button alone strobes load_new_c
    enter_digit(4'd4);
    time_button = 1'b1;
    #1 check("t3_load_c", {3'b0, outs}, {3'b0, O_LDC});
    tick();
    time_button = 1'b0;
    #1 check("t3_load_c_exit", {3'b0, outs}, {3'b0, O_IDLE});

    // Test 4: count restarts on KEY_WAITED->KEY_ENTRY; 10th pulse times out
    key = 4'd1;
    tick(); tick();
    for (int i = 0; i < 5; i++) pulse_sec();
    check("t4_waited_tcnt", {4'b0, dut.tcnt_q}, 8'd5);
    key = NK;
    tick();
    check("t4_entry", {3'b0, outs}, {3'b0, O_ENTRY});
    for (int i = 0; i < 9; i++) pulse_sec();
    check("t4_after9", {3'b0, outs}, {3'b0, O_ENTRY});
    pulse_sec();
    check("t4_after10", {3'b0, outs}, {3'b0, O_IDLE});

    // Test 5: key never released, timeout from KEY_WAITED
    key = 4'd2;
    tick(); tick();
    for (int i = 0; i < 9; i++) pulse_sec();
    check("t5_after9", {3'b0, outs}, {3'b0, O_ENTRY});
    pulse_sec();
    check("t5_after10", {3'b0, outs}, {3'b0, O_IDLE});
    key = NK;
    tick();
    check("t5_idle", {3'b0, outs}, {3'b0, O_IDLE});

    // Test 6: key beats time_out in KEY_ENTRY
    enter_digit(4'd8);
    for (int i = 0; i < 9; i++) pulse_sec();
    key = 4'd5;
    pulse_sec();
    check("t6_key_wins", {3'b0, outs}, {3'b0, O_SHIFT});
    key = NK;
    tick();
    check("t6_waited", {3'b0, outs}, {3'b0, O_ENTRY});
    tick();

    // Test 1: reset mid-KEY_ENTRY with tcnt=5
    for (int i = 0; i < 5; i++) pulse_sec();
    check("t1_tcnt5", {4'b0, dut.tcnt_q}, 8'd5);
    reset = 1'b1;
    #1 check("t1_outs_same_cycle", {3'b0, outs}, {3'b0, O_IDLE});
    tick();
    check("t1_outs_after", {3'b0, outs}, {3'b0, O_IDLE});
    check("t1_tcnt0", {4'b0, dut.tcnt_q}, 8'd0);
    reset = 1'b0;
    alarm_button = 1'b1;
    tick();
    check("t1_from_show_time", {3'b0, outs}, {3'b0, O_ALARM});
    alarm_button = 1'b0;
    tick();
    check("t1_final_idle", {3'b0, outs}, {3'b0, O_IDLE});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
